return_addr_stack: RTL and testbench

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

---
 rtl/return_addr_stack_pkg.sv | 17 +
 rtl/return_addr_stack.sv | 91 +++++++++
 tb/tb_return_addr_stack.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/return_addr_stack_pkg.sv
// Shared core definitions: predecode jump classification and the default
// return-address-stack depth, used by predecode and by return_addr_stack.
package return_addr_stack_pkg;

  localparam int RAS_DEPTH = 8;

  typedef enum logic [2:0] {
    JT_NONE = 3'd0,
    JT_BR   = 3'd1,
    JT_RET  = 3'd2,
    JT_J    = 3'd3,
    JT_JR   = 3'd4,
    JT_JAL  = 3'd5,
    JT_JALR = 3'd6
  } jump_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: calls push pc+4, returns pop and predict,
// with checkpoint outputs and a flush port that restores a checkpoint.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PC_W  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [2:0]       pd_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush,
  input  logic [IDX_W-1:0] restore_tos,
  input  logic [CNT_W-1:0] restore_cnt,
  input  logic [PC_W-1:0]  restore_top,
  output logic             pred_valid,
  output logic [PC_W-1:0]  pred_addr,
  output logic [IDX_W-1:0] ckpt_tos,
  output logic [CNT_W-1:0] ckpt_cnt,
  output logic [PC_W-1:0]  ckpt_top
);

  localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  INSN_BYTES = PC_W'(4);

  logic [PC_W-1:0]  entry_q [DEPTH];
  logic [IDX_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [PC_W-1:0]  wr_data;
  jump_t            pd_code;
  logic             is_push, is_pop, not_empty;

  always_comb begin
    pd_code   = jump_t'(pd_in);
    is_push   = valid_in && (pd_code == JT_JAL || pd_code == JT_JALR);
    is_pop    = valid_in && (pd_code == JT_RET);
    not_empty = (cnt_q != '0);

    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = '0;

    // Prediction reads the pre-update top; a flush suppresses it.
    pred_valid = is_pop && not_empty && !flush;
    pred_addr  = entry_q[tos_q];

    ckpt_tos = tos_q;
    ckpt_cnt = cnt_q;
    ckpt_top = entry_q[tos_q];

    if (flush) begin
      tos_d   = restore_tos;
      cnt_d   = restore_cnt;
      wr_en   = 1'b1;
      wr_idx  = restore_tos;
      wr_data = restore_top;
    end else if (is_push) begin
      // When full the pointer wraps onto the oldest entry and cnt pins at DEPTH.
      tos_d   = tos_q + IDX_W'(1);
      wr_en   = 1'b1;
      wr_idx  = tos_q + IDX_W'(1);
      wr_data = pc_in + INSN_BYTES;
      cnt_d   = (cnt_q == FULL) ? FULL : cnt_q + CNT_W'(1);
    end else if (is_pop && not_empty) begin
      tos_d = tos_q - IDX_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Entry contents are deliberately not reset; cnt == 0 hides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) entry_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed scenarios with literal targets plus
// randomized traffic checked every cycle against a circular-buffer model.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int PC_W  = 64;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [2:0]       pd_in;
  logic [PC_W-1:0]  pc_in;
  logic             flush;
  logic [IDX_W-1:0] restore_tos;
  logic [CNT_W-1:0] restore_cnt;
  logic [PC_W-1:0]  restore_top;
  logic             pred_valid;
  logic [PC_W-1:0]  pred_addr;
  logic [IDX_W-1:0] ckpt_tos;
  logic [CNT_W-1:0] ckpt_cnt;
  logic [PC_W-1:0]  ckpt_top;

  return_addr_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pd_in(pd_in), .pc_in(pc_in),
    .flush(flush), .restore_tos(restore_tos), .restore_cnt(restore_cnt),
    .restore_top(restore_top), .pred_valid(pred_valid), .pred_addr(pred_addr),
    .ckpt_tos(ckpt_tos), .ckpt_cnt(ckpt_cnt), .ckpt_top(ckpt_top)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stack held as a ring of DEPTH slots addressed with integer arithmetic.
  logic [PC_W-1:0] m_mem   [DEPTH];
  bit              m_known [DEPTH];
  int              m_tos = 0;
  int              m_cnt = 0;
  bit              live  = 0;

  always @(negedge clk) begin
    bit exp_pv;
    if (live) begin
      chk("ckpt_tos", PC_W'(ckpt_tos), PC_W'(m_tos));
      chk("ckpt_cnt", PC_W'(ckpt_cnt), PC_W'(m_cnt));
      if (m_known[m_tos]) chk("ckpt_top", ckpt_top, m_mem[m_tos]);
      if (!reset) begin
        exp_pv = !flush && valid_in && pd_in == 3'd2 && m_cnt > 0;
        chk("pred_valid", PC_W'(pred_valid), PC_W'(exp_pv));
        if (exp_pv && m_known[m_tos]) chk("pred_addr", pred_addr, m_mem[m_tos]);
      end
    end
    if (reset) begin
      live  = 1;
      m_tos = 0;
      m_cnt = 0;
    end else if (live) begin
      if (flush) begin
        m_tos = int'(restore_tos);
        m_cnt = int'(restore_cnt);
        m_mem[m_tos]   = restore_top;
        m_known[m_tos] = 1;
      end else if (valid_in && (pd_in == 3'd5 || pd_in == 3'd6)) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos]   = pc_in + 64'd4;
        m_known[m_tos] = 1;
        m_cnt = (m_cnt == DEPTH) ? DEPTH : m_cnt + 1;
      end else if (valid_in && pd_in == 3'd2 && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    valid_in = 1'b0; pd_in = 3'd0; pc_in = '0; flush = 1'b0; reset = 1'b0;
    restore_tos = '0; restore_cnt = '0; restore_top = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1;
    step();
  endtask

  task automatic push(input logic [2:0] pd, input logic [PC_W-1:0] pc);
    idle(); valid_in = 1'b1; pd_in = pd; pc_in = pc;
    step();
  endtask

  // Pops and compares against the next literal target on the scoreboard.
  task automatic pop_expect(input bit exp_valid);
    logic [PC_W-1:0] e;
    idle(); valid_in = 1'b1; pd_in = 3'd2;
    @(negedge clk);
    chk("lit_pred_valid", PC_W'(pred_valid), PC_W'(exp_valid));
    if (exp_valid) begin
      e = exp_q.pop_front();
      chk("lit_pred_addr", pred_addr, e);
    end
    step();
  endtask

  task automatic do_flush(input logic [IDX_W-1:0] t, input logic [CNT_W-1:0] c,
                          input logic [PC_W-1:0] top, input bit with_push);
    idle(); flush = 1'b1; restore_tos = t; restore_cnt = c; restore_top = top;
    if (with_push) begin valid_in = 1'b1; pd_in = 3'd5; pc_in = 64'h9990; end
    @(negedge clk);
    chk("flush_pred_valid", PC_W'(pred_valid), 64'd0);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    do_reset();
    @(negedge clk);
    chk("reset_cnt", PC_W'(ckpt_cnt), 64'd0);
    chk("reset_tos", PC_W'(ckpt_tos), 64'd0);
    @(posedge clk); #1;

    // Single call/return
    push(3'd5, 64'h1000);
    exp_q.push_back(64'h1004);
    pop_expect(1);
    @(negedge clk);
    chk("cnt_after_pair", PC_W'(ckpt_cnt), 64'd0);
    @(posedge clk); #1;

    // Empty pop leaves state alone
    pop_expect(0);

    // Nested calls
    push(3'd5, 64'h100); push(3'd6, 64'h200); push(3'd5, 64'h300);
    exp_q.push_back(64'h304); exp_q.push_back(64'h204); exp_q.push_back(64'h104);
    repeat (3) pop_expect(1);

    // Overflow: 9 calls into 8 entries
    do_reset();
    for (int k = 1; k <= 9; k++) push(3'd5, 64'(16 * k));
    for (int k = 9; k >= 2; k--) exp_q.push_back(64'(16 * k + 4));
    repeat (8) pop_expect(1);
    pop_expect(0);

    // Non-call codes change nothing
    push(3'd5, 64'h700);
    for (int c = 0; c <= 4; c++) if (c != 2) push(3'(c), 64'h1234);
    exp_q.push_back(64'h704);
    pop_expect(1);

    // Checkpoint and restore
    do_reset();
    push(3'd5, 64'h100); push(3'd5, 64'h200);
    @(negedge clk);
    chk("ckpt_tos_lit", PC_W'(ckpt_tos), 64'd2);
    chk("ckpt_cnt_lit", PC_W'(ckpt_cnt), 64'd2);
    chk("ckpt_top_lit", ckpt_top, 64'h204);
    @(posedge clk); #1;
    push(3'd5, 64'h500);
    exp_q.push_back(64'h504); exp_q.push_back(64'h204);
    pop_expect(1); pop_expect(1);
    do_flush(3'd2, 4'd2, 64'h204, 0);
    exp_q.push_back(64'h204); exp_q.push_back(64'h104);
    pop_expect(1); pop_expect(1);

    // Flush beats a same-cycle call
    do_flush(3'd5, 4'd1, 64'hABC0, 1);
    exp_q.push_back(64'hABC0);
    pop_expect(1);
    pop_expect(0);

    // Carry out of pc+4 is dropped
    push(3'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    exp_q.push_back(64'h2);
    pop_expect(1);

    // Reset discards pending state
    push(3'd5, 64'h800);
    do_reset();
    pop_expect(0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      idle();
      reset    = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 99) < 4);
      valid_in = ($urandom_range(0, 9) < 8);
      pd_in    = 3'($urandom_range(0, 6));
      pc_in    = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC - 64'($urandom_range(0, 3))
                                             : {32'($urandom), 32'($urandom)};
      restore_tos = IDX_W'($urandom_range(0, DEPTH - 1));
      restore_cnt = CNT_W'($urandom_range(0, DEPTH));
      restore_top = {32'($urandom), 32'($urandom)};
      step();
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
